nibble_serial_adder_ctrl: RTL

Sequencer that performs wide additions (4*NIBBLES bits) by reusing a single 4-bit add slice ({c,s} = a4 + b4 + carry) once per cycle, least-significant nibble first.
- The carry between slices is held in a register.
- Operands are accepted and results returned over valid/ready handshakes.
- Sits between an operand producer and a result consumer as an area-saving alternative to a full-width adder.

---
 rtl/nibble_serial_adder_ctrl_if.sv | 41 ++++
 rtl/nibble_serial_adder_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl_if
// Description : Handshake/data bundle for the nibble-serial adder sequencer.
//               The producer drives in_valid, a, b and cin. The consumer
//               drives out_ready. The sequencer returns the result, status
//               and debug signals.
//               master : producer/consumer side (testbench or system)
//               slave  : sequencer side
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     sum;
  logic             cout;
  logic             busy;
  logic [IDX_W-1:0] nib_idx;
  logic [7:0]       done_count;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy, nib_idx, done_count
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy, nib_idx, done_count
  );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Wide unsigned adder (4*NIBBLES bits) built from one 4-bit add
//               slice reused once per cycle, least-significant nibble first.
//               The inter-slice carry lives in a register. Operands arrive
//               and results leave over valid/ready handshakes.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - slave modport of nibble_serial_adder_ctrl_if:
//                       in_valid/in_ready/a/b/cin   operand handshake
//                       out_valid/out_ready/sum/cout result handshake
//                       busy, nib_idx, done_count   status and debug
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  nibble_serial_adder_ctrl_if.slave   bus
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q,      state_d;
  logic [W-1:0]     a_q,          a_d;
  logic [W-1:0]     b_q,          b_d;
  logic             carry_q,      carry_d;
  logic [IDX_W-1:0] idx_q,        idx_d;
  logic [W-1:0]     sum_q,        sum_d;
  logic             cout_q,       cout_d;
  logic [7:0]       done_count_q, done_count_d;
  logic             in_ready_q,   in_ready_d;
  logic             out_valid_q,  out_valid_d;
  logic             busy_q,       busy_d;

  // The single shared 4-bit slice: operand nibbles picked by the current index.
  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [4:0] slice;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == n[IDX_W-1:0]) begin
        a_nib = a_q[4*n +: 4];
        b_nib = b_q[4*n +: 4];
      end
    end
    slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    carry_d      = carry_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    done_count_d = done_count_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.a;
          b_d        = bus.b;
          carry_d    = bus.cin;
          idx_d      = '0;
          sum_d      = '0;
          state_d    = ST_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      ST_RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == n[IDX_W-1:0]) begin
            sum_d[4*n +: 4] = slice[3:0];
          end
        end
        carry_d = slice[4];
        if (idx_q == LAST_IDX) begin
          cout_d      = slice[4];
          idx_d       = '0;
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        // Result held until the consumer takes it; in_valid is ignored here.
        if (bus.out_ready) begin
          done_count_d = done_count_q + 8'd1;
          state_d      = ST_IDLE;
          out_valid_d  = 1'b0;
          in_ready_d   = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle.
        state_d     = ST_IDLE;
        idx_d       = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      carry_q      <= 1'b0;
      idx_q        <= '0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      done_count_q <= 8'd0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      carry_q      <= carry_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      done_count_q <= done_count_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sum        = sum_q;
  assign bus.cout       = cout_q;
  assign bus.busy       = busy_q;
  assign bus.nib_idx    = idx_q;
  assign bus.done_count = done_count_q;

endmodule
`default_nettype wire
